// File: rtl/ldpc_mem_reader.sv
// ldpc_mem_reader: Avalon-MM read initiator that streams a contiguous block of
// words from the LDPC on-chip RAM (read latency 1) into a valid/ready stream.
// A small skid FIFO absorbs reads already in flight when the stream stalls.
// Optional feature macro: LDPC_MEM_READER_CHECKSUM_EN adds a running XOR of all
// popped stream words on the checksum output.
module ldpc_mem_reader #(
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    input  logic [DATA_W-1:0] avm_readdata,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
`ifdef LDPC_MEM_READER_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic              st_last
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = PTR_W + 2;
    localparam int unsigned CW    = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  base_q;
    logic [CW-1:0]      count_q;
    logic [CW-1:0]      issued_q;
    logic               cs_last_q;
    logic               pend_q;
    logic               pend_last_q;
    logic [DATA_W-1:0]  fifo_data [FIFO_DEPTH];
    logic               fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   fifo_cnt;

    logic               pop;
    logic               wr;
    logic [CNT_W-1:0]   cnt_after_pop;
    logic [CNT_W-1:0]   cnt_next;
    logic [PTR_W-1:0]   rd_ptr_next;
    logic [OCC_W-1:0]   occ;
    logic               credit_ok;
    logic [DATA_W-1:0]  head_data_next;
    logic               head_last_next;

    // The slave is read-only from this side with full-word accesses.
    assign avm_write      = 1'b0;
    assign avm_byteenable = 4'hF;

    // FIFO bookkeeping, read credit and next-head selection (with write bypass into an empty FIFO).
    always_comb begin
        pop            = st_valid & st_ready;
        wr             = pend_q;
        cnt_after_pop  = fifo_cnt - CNT_W'(pop);
        cnt_next       = cnt_after_pop + CNT_W'(wr);
        rd_ptr_next    = rd_ptr + PTR_W'(pop);
        // Buffered words plus the read whose data lands next cycle; a new read adds one more.
        occ            = OCC_W'(cnt_next) + OCC_W'(avm_chipselect);
        credit_ok      = (occ < OCC_W'(FIFO_DEPTH));
        head_data_next = fifo_data[rd_ptr_next];
        head_last_next = fifo_last[rd_ptr_next];
        if (wr && (cnt_after_pop == '0)) begin
            head_data_next = avm_readdata;
            head_last_next = pend_last_q;
        end
    end

    // Control FSM, read issue, FIFO storage and registered stream outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            base_q         <= '0;
            count_q        <= '0;
            issued_q       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            avm_address    <= '0;
            avm_chipselect <= 1'b0;
            cs_last_q      <= 1'b0;
            pend_q         <= 1'b0;
            pend_last_q    <= 1'b0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            fifo_cnt       <= '0;
            st_valid       <= 1'b0;
            st_data        <= '0;
            st_last        <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
`ifdef LDPC_MEM_READER_CHECKSUM_EN
            checksum       <= '0;
`endif
        end else begin
            done           <= 1'b0;
            avm_chipselect <= 1'b0;
            cs_last_q      <= 1'b0;

            // Read return lands one cycle after the request; credit guarantees room.
            pend_q      <= avm_chipselect;
            pend_last_q <= cs_last_q;
            if (wr) begin
                fifo_data[wr_ptr] <= avm_readdata;
                fifo_last[wr_ptr] <= pend_last_q;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            rd_ptr   <= rd_ptr_next;
            fifo_cnt <= cnt_next;

            st_valid <= (cnt_next != '0);
            st_data  <= head_data_next;
            st_last  <= head_last_next & (cnt_next != '0);

`ifdef LDPC_MEM_READER_CHECKSUM_EN
            if (state == IDLE && start) begin
                checksum <= '0;
            end else if (pop) begin
                checksum <= checksum ^ st_data;
            end
`endif

            case (state)
                IDLE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        count_q <= word_count;
                        busy    <= 1'b1;
                        if (word_count == '0) begin
                            issued_q <= '0;
                            state    <= DRAIN;
                        end else begin
                            avm_chipselect <= 1'b1;
                            avm_address    <= base_addr;
                            cs_last_q      <= (word_count == CW'(1));
                            issued_q       <= CW'(1);
                            state          <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issued_q == count_q) begin
                        state <= DRAIN;
                    end else if (credit_ok) begin
                        avm_chipselect <= 1'b1;
                        avm_address    <= base_q + issued_q[ADDR_W-1:0];
                        cs_last_q      <= (issued_q == count_q - CW'(1));
                        issued_q       <= issued_q + CW'(1);
                    end
                end
                DRAIN: begin
                    if ((count_q == '0) || (pop && st_last)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ldpc_mem_reader.sv
// Testbench for ldpc_mem_reader: memory slave model, scoreboard of expected
// stream words and read addresses, decoupled monitor, directed and random runs.
module tb_ldpc_mem_reader;

    localparam int unsigned AW    = 13;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MEM_N = 8192;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   word_count = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] avm_address;
    logic          avm_chipselect;
    logic          avm_write;
    logic [3:0]    avm_byteenable;
    logic [DW-1:0] avm_readdata = '0;
    logic [DW-1:0] st_data;
    logic          st_valid;
    logic          st_ready = 1'b1;
    logic          st_last;
`ifdef LDPC_MEM_READER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    ldpc_mem_reader #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .busy           (busy),
        .done           (done),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write      (avm_write),
        .avm_byteenable (avm_byteenable),
        .avm_readdata   (avm_readdata),
        .st_data        (st_data),
        .st_valid       (st_valid),
        .st_ready       (st_ready),
`ifdef LDPC_MEM_READER_CHECKSUM_EN
        .checksum       (checksum),
`endif
        .st_last        (st_last)
    );

    always #5 clk = ~clk;

    // Memory slave: fixed read latency of one cycle
    logic [DW-1:0] mem [MEM_N];
    always @(posedge clk) avm_readdata <= mem[avm_address];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] exp_data [$];
    bit            exp_last [$];
    logic [AW-1:0] exp_addr [$];
    logic [DW-1:0] exp_xor;

    int cs_total = 0;
    int pop_total = 0;
    int max_occ = 0;
    int cs_xfer = 0;
    int first_valid_cyc = -1;
    int start_cyc = 0;
    int mode = 0;
    int ph = 0;
    bit prev_stall = 0;
    logic [DW-1:0] prev_data = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT issues a read or presents a word
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(st_valid), 64'(1));
                chk("hold_data", 64'(st_data), 64'(prev_data));
            end
            if (avm_chipselect) begin
                cs_total++;
                cs_xfer++;
                if (exp_addr.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_read: address %0h, no read expected", avm_address);
                end else begin
                    chk("read_addr", 64'(avm_address), 64'(exp_addr.pop_front()));
                end
            end
            if (st_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (st_valid && st_ready) begin
                pop_total++;
                if (exp_data.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: data %0h, no word expected", st_data);
                end else begin
                    chk("st_data", 64'(st_data), 64'(exp_data.pop_front()));
                    chk("st_last", 64'(st_last), 64'(exp_last.pop_front()));
                end
            end
            chk("occupancy_le_depth", 64'((cs_total - pop_total) <= int'(DEPTH)), 64'(1));
            if (cs_total - pop_total > max_occ) max_occ = cs_total - pop_total;
            prev_stall = st_valid && !st_ready;
            prev_data  = st_data;
        end
    end

    // Stream sink readiness patterns
    initial forever begin
        @(posedge clk);
        #1;
        case (mode)
            0: st_ready = 1'b1;
            1: st_ready = (ph == 0) || (ph == 3);
            2: st_ready = ($urandom_range(0, 3) != 0);
            default: st_ready = ((cyc - start_cyc) > 12);
        endcase
        ph = (ph + 1) % 4;
    end

    // Load the expected reads and words for one block from the reference memory
    task automatic load_expect(input int base, input int cnt);
        exp_xor = '0;
        for (int i = 0; i < cnt; i++) begin
            int a;
            a = (base + i) % int'(MEM_N);
            exp_addr.push_back(AW'(a));
            exp_data.push_back(mem[a]);
            exp_last.push_back(i == cnt - 1);
            exp_xor = exp_xor ^ mem[a];
        end
    endtask

    // Issue one transfer starting in the current cycle; returns during the done cycle
    task automatic run_xfer(input int base, input int cnt, input int md, input bit inj);
        bit got;
        chk("queues_empty_before_start", 64'(exp_data.size() + exp_addr.size()), 64'(0));
        load_expect(base, cnt);
        mode = md;
        ph = 0;
        max_occ = 0;
        cs_xfer = 0;
        first_valid_cyc = -1;
        start_cyc = cyc;
        base_addr = AW'(base);
        word_count = (AW+1)'(cnt);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(1));
        if (inj) begin
            repeat (2) @(posedge clk);
            #1;
            base_addr = AW'(13'h500);
            word_count = (AW+1)'(3);
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        got = 0;
        for (int k = 0; k < 4000; k++) begin
            if (done) begin
                got = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: no done within budget (base %0h count %0d)", base, cnt);
        end else begin
            chk("busy_low_at_done", 64'(busy), 64'(0));
            chk("queues_empty_at_done", 64'(exp_data.size() + exp_addr.size()), 64'(0));
`ifdef LDPC_MEM_READER_CHECKSUM_EN
            chk("checksum", 64'(checksum), 64'(exp_xor));
`endif
            if (cnt == 0) begin
                chk("zero_done_latency", 64'(cyc - start_cyc), 64'(2));
                chk("zero_no_reads", 64'(cs_xfer), 64'(0));
                chk("zero_no_valid", 64'(first_valid_cyc < 0), 64'(1));
            end else if (md == 0) begin
                chk("first_valid_latency", 64'(first_valid_cyc - start_cyc), 64'(3));
                chk("done_latency", 64'(cyc - start_cyc), 64'(cnt + 3));
            end
        end
    endtask

    initial begin
        bit got;
        for (int i = 0; i < int'(MEM_N); i++) mem[i] = DW'(i) * 32'h0101_0101;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_cs", 64'(avm_chipselect), 64'(0));
        chk("rst_addr", 64'(avm_address), 64'(0));
        chk("rst_valid", 64'(st_valid), 64'(0));
        chk("rst_last", 64'(st_last), 64'(0));
        chk("rst_data", 64'(st_data), 64'(0));
        chk("tie_write", 64'(avm_write), 64'(0));
        chk("tie_byteenable", 64'(avm_byteenable), 64'(4'hF));
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed: full rate, stall pattern with ignored start, hard stall, wrap, empty block
        run_xfer(32'h10, 8, 0, 0);
        @(posedge clk);
        #1;
        run_xfer(32'h10, 8, 1, 1);
        run_xfer(32'h20, 8, 3, 0);
        chk("fifo_fills_to_depth", 64'(max_occ), 64'(DEPTH));
        run_xfer(32'h1FFE, 4, 0, 0);
        run_xfer(32'h30, 0, 0, 0);
        run_xfer(32'h77, 1, 0, 0);

        // Reset in the middle of a block after three words have been popped
        @(posedge clk);
        #1;
        load_expect(32'h40, 10);
        mode = 0;
        base_addr = AW'(13'h40);
        word_count = (AW+1)'(10);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        got = 0;
        for (int k = 0; k < 100; k++) begin
            if (pop_total % 1000000 >= 0 && exp_data.size() <= 7) begin
                got = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("three_pops_before_reset", 64'(got), 64'(1));
        reset = 1'b1;
        exp_data.delete();
        exp_last.delete();
        exp_addr.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cs_total = 0;
        pop_total = 0;
        chk("post_reset_busy", 64'(busy), 64'(0));
        chk("post_reset_valid", 64'(st_valid), 64'(0));
        @(posedge clk);
        #1;
        run_xfer(0, 2, 0, 0);

`ifdef LDPC_MEM_READER_CHECKSUM_EN
        @(posedge clk);
        #1;
        mem[32'h200] = 32'hA5A5_A5A5;
        mem[32'h201] = 32'h0F0F_0F0F;
        mem[32'h202] = 32'hFFFF_FFFF;
        run_xfer(32'h200, 3, 0, 0);
        chk("checksum_known_vector", 64'(checksum), 64'(32'h5555_5555));
        repeat (3) @(posedge clk);
        #1;
        chk("checksum_holds", 64'(checksum), 64'(32'h5555_5555));
`endif

        // Random memory contents, bases, lengths and backpressure
        for (int i = 0; i < int'(MEM_N); i++) mem[i] = $urandom;
        for (int t = 0; t < 25; t++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            run_xfer(int'($urandom_range(0, MEM_N - 1)), int'($urandom_range(0, 24)),
                     int'($urandom_range(0, 2)), 0);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("idle_at_end", 64'(busy), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
